// File: rtl/tt_um_add_sequencer_if.sv
// Tile pin bundle for the add sequencer: dedicated inputs, bidirectional pins
// and result outputs, viewed from the driver (master) or the tile (slave).
interface tt_um_add_sequencer_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_add_sequencer.sv
// Operand sequencer around one 8-bit adder: strobe-paced pair add or running
// accumulate, with acknowledge handshake, sticky error flag and level clear.
module tt_um_add_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  tt_um_add_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HAVE_A = 2'd1,
    ST_EXEC   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Control bits in pin order: [0] STB, [1] MODE, [2] CLR, [3] ACK
  logic [SYNC_STAGES-1:0][3:0] sync_reg;
  logic [3:0] ctrl_sync;
  logic       stb_d_reg, ack_d_reg;
  logic       stb_p, ack_p, mode_lvl, clr_lvl;

  state_t     state_reg, state_next;
  logic [7:0] a_reg, a_next;
  logic [7:0] b_reg, b_next;
  logic [7:0] r_reg, r_next;
  logic       carry_reg, carry_next;
  logic       err_reg, err_next;

  logic       unused_pins;
  assign unused_pins = &{1'b0, bus.ena, bus.uio_in[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      stb_d_reg <= 1'b0;
      ack_d_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], bus.uio_in[7:4]};
      stb_d_reg <= ctrl_sync[0];
      ack_d_reg <= ctrl_sync[3];
    end
  end

  assign ctrl_sync = sync_reg[SYNC_STAGES-1];
  assign stb_p     = ctrl_sync[0] & ~stb_d_reg;
  assign ack_p     = ctrl_sync[3] & ~ack_d_reg;
  assign mode_lvl  = ctrl_sync[1];
  assign clr_lvl   = ctrl_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      carry_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      r_reg     <= r_next;
      carry_reg <= carry_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    r_next     = r_reg;
    carry_next = carry_reg;
    err_next   = err_reg;
    if (clr_lvl) begin
      state_next = ST_IDLE;
      a_next     = '0;
      b_next     = '0;
      r_next     = '0;
      carry_next = 1'b0;
      err_next   = 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (stb_p) begin
            if (mode_lvl) begin
              {carry_next, r_next} = {1'b0, r_reg} + {1'b0, bus.ui_in};
            end else begin
              a_next     = bus.ui_in;
              state_next = ST_HAVE_A;
            end
          end
        end
        ST_HAVE_A: begin
          // Mode was latched by the first strobe; the second is always B
          if (stb_p) begin
            b_next     = bus.ui_in;
            state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          {carry_next, r_next} = {1'b0, a_reg} + {1'b0, b_reg};
          state_next = ST_DONE;
          if (stb_p) err_next = 1'b1;
        end
        ST_DONE: begin
          if (stb_p) err_next = 1'b1;
          if (ack_p) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign bus.uo_out  = r_reg;
  assign bus.uio_out = {4'b0000, err_reg, carry_reg, state_reg == ST_DONE,
                        (state_reg == ST_IDLE) || (state_reg == ST_HAVE_A)};
  assign bus.uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_add_sequencer.sv
// Self-checking bench for tt_um_add_sequencer: vector table of pair adds,
// hand-written corner sequences, then random traffic against a simple model.
`timescale 1ns/1ps
module tb_tt_um_add_sequencer;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tt_um_add_sequencer_if bus();

  tt_um_add_sequencer #(.SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
  } vec_t;

  vec_t vecs[6];

  // Behavioural model state
  int         m_r, m_c, m_err, m_a;
  bit         m_have_a, m_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    bus.ui_in     = v;
    bus.uio_in[4] = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    bus.uio_in[4] = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic ack();
    @(negedge clk);
    bus.uio_in[7] = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    bus.uio_in[7] = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.uio_in[6] = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    bus.uio_in[6] = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic set_mode(input logic m);
    @(negedge clk);
    bus.uio_in[5] = m;
    repeat (SYNC + 1) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.uio_out[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " done"}, int'(bus.uio_out[1]), 1);
  endtask

  // Raise STB and count rising edges until READY falls and DONE rises
  task automatic strobe_timed(input logic [7:0] v, output int ready_fall, output int done_at);
    ready_fall = -1;
    done_at    = -1;
    @(negedge clk);
    bus.ui_in     = v;
    bus.uio_in[4] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (ready_fall < 0 && !bus.uio_out[0]) ready_fall = n;
      if (bus.uio_out[1]) begin
        done_at = n;
        break;
      end
    end
    @(negedge clk);
    bus.uio_in[4] = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic model_strobe(input int v, input bit mode);
    int s;
    if (m_done) begin
      m_err = 1;
    end else if (m_have_a) begin
      s        = m_a + v;
      m_r      = s % 256;
      m_c      = (s > 255) ? 1 : 0;
      m_have_a = 0;
      m_done   = 1;
    end else if (mode) begin
      s   = m_r + v;
      m_r = s % 256;
      m_c = (s > 255) ? 1 : 0;
    end else begin
      m_a      = v;
      m_have_a = 1;
    end
  endtask

  task automatic compare_model(input int step);
    string tag;
    tag = $sformatf("rnd%0d", step);
    check({tag, " R"},     int'(bus.uo_out),     m_r);
    check({tag, " CARRY"}, int'(bus.uio_out[2]), m_c);
    check({tag, " ERR"},   int'(bus.uio_out[3]), m_err);
    check({tag, " DONE"},  int'(bus.uio_out[1]), int'(m_done));
    check({tag, " READY"}, int'(bus.uio_out[0]), int'(!m_done));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rf, da, kind, v;
    bit md;

    vecs[0] = '{a: 8'd200, b: 8'd100, r: 8'd44,  c: 1'b1};
    vecs[1] = '{a: 8'd255, b: 8'd1,   r: 8'd0,   c: 1'b1};
    vecs[2] = '{a: 8'd0,   b: 8'd0,   r: 8'd0,   c: 1'b0};
    vecs[3] = '{a: 8'd128, b: 8'd127, r: 8'd255, c: 1'b0};
    vecs[4] = '{a: 8'd255, b: 8'd255, r: 8'd254, c: 1'b1};
    vecs[5] = '{a: 8'd60,  b: 8'd70,  r: 8'd130, c: 1'b0};

    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;

    // Reset values, during and after reset
    repeat (3) @(negedge clk);
    check("rst uo_out",  int'(bus.uo_out),  0);
    check("rst uio_out", int'(bus.uio_out), 8'h01);
    check("rst uio_oe",  int'(bus.uio_oe),  8'h0F);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post-rst uio_out", int'(bus.uio_out), 8'h01);

    // Table of pair adds with acknowledge
    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("vec%0d %0d+%0d", i, vecs[i].a, vecs[i].b);
      strobe(vecs[i].a);
      check({tag, " READY in HAVE_A"}, int'(bus.uio_out[0]), 1);
      strobe(vecs[i].b);
      wait_done(tag);
      check({tag, " R"},     int'(bus.uo_out),     int'(vecs[i].r));
      check({tag, " CARRY"}, int'(bus.uio_out[2]), int'(vecs[i].c));
      check({tag, " READY"}, int'(bus.uio_out[0]), 0);
      ack();
      check({tag, " ack READY"}, int'(bus.uio_out[0]), 1);
      check({tag, " ack DONE"},  int'(bus.uio_out[1]), 0);
      check({tag, " R holds"},   int'(bus.uo_out),     int'(vecs[i].r));
    end

    // Latency from the B strobe pin edge
    strobe(8'd17);
    strobe_timed(8'd25, rf, da);
    check("timed READY fall edge", rf, SYNC + 1);
    check("timed DONE edge",       da, SYNC + 2);
    check("timed R",     int'(bus.uo_out),     42);
    check("timed CARRY", int'(bus.uio_out[2]), 0);
    ack();

    // Accumulate seeded from the pair-add result
    set_mode(1'b1);
    strobe(8'd10);
    check("acc1 R",     int'(bus.uo_out),     52);
    check("acc1 CARRY", int'(bus.uio_out[2]), 0);
    check("acc1 READY/DONE", int'(bus.uio_out[1:0]), 1);
    strobe(8'd250);
    check("acc2 R",     int'(bus.uo_out),     46);
    check("acc2 CARRY", int'(bus.uio_out[2]), 1);
    check("acc2 READY/DONE", int'(bus.uio_out[1:0]), 1);

    // Strobe while DONE sets sticky ERR; CLR wipes everything
    set_mode(1'b0);
    strobe(8'd3);
    strobe(8'd4);
    wait_done("err-seq");
    strobe(8'd5);
    check("err ERR",   int'(bus.uio_out[3]), 1);
    check("err R",     int'(bus.uo_out),     7);
    ack();
    check("err ack READY", int'(bus.uio_out[0]), 1);
    check("err sticky",    int'(bus.uio_out[3]), 1);
    pulse_clr();
    check("clr uo_out",  int'(bus.uo_out),  0);
    check("clr uio_out", int'(bus.uio_out), 8'h01);

    // CLR in HAVE_A discards the stale A
    strobe(8'd9);
    pulse_clr();
    strobe(8'd1);
    strobe(8'd2);
    wait_done("clr-have-a");
    check("clr-have-a R", int'(bus.uo_out), 3);
    ack();

    // ACK outside DONE is ignored
    ack();
    check("ack idle uio_out", int'(bus.uio_out), 8'h01);
    strobe(8'd7);
    ack();
    check("ack have_a uio_out", int'(bus.uio_out), 8'h01);
    strobe(8'd8);
    wait_done("ack-have-a");
    check("ack-have-a R", int'(bus.uo_out), 15);
    ack();

    // Asynchronous reset while in EXEC
    strobe(8'd20);
    @(negedge clk);
    bus.ui_in     = 8'd30;
    bus.uio_in[4] = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    check("exec READY", int'(bus.uio_out[0]), 0);
    #1 rst_n = 1'b0;
    #1;
    check("async rst uo_out",  int'(bus.uo_out),  0);
    check("async rst uio_out", int'(bus.uio_out), 8'h01);
    check("async rst uio_oe",  int'(bus.uio_oe),  8'h0F);
    bus.uio_in[4] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check("post async rst uio_out", int'(bus.uio_out), 8'h01);

    // Random traffic against the model
    m_r = 0; m_c = 0; m_err = 0; m_a = 0; m_have_a = 0; m_done = 0;
    for (int step = 0; step < 60; step++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 5) begin
        md = 1'($urandom_range(0, 1));
        v  = int'($urandom_range(0, 255));
        set_mode(md);
        strobe(8'(v));
        model_strobe(v, md);
      end else if (kind <= 8) begin
        ack();
        if (m_done) m_done = 0;
      end else begin
        pulse_clr();
        m_r = 0; m_c = 0; m_err = 0; m_a = 0; m_have_a = 0; m_done = 0;
      end
      compare_model(step);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
